// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: buffers {j,k} commands in a small FIFO and replays each one to a JK flip-flop with a one-cycle update strobe.
// Latency: a push into an empty FIFO at edge N shows on j/k after N+1, ff_en is high in cycle N+TICK_DIV, and issued updates at N+TICK_DIV+2.
// Backpressure: cmd_ready = !full, derived from the registered level, so it stays low in a full cycle even if a pop happens then.
// Optional build macro JK_SEQ_CHECK_EN adds a JK reference model that checks q_in after every update (sticky mismatch flag).

module jk_cmd_seq #(
    parameter int DEPTH    = 4,   // power of two, 2..16
    parameter int TICK_DIV = 4    // cycles j/k are held before the strobe, 1..255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd,
    output logic                     cmd_ready,
    output logic                     j,
    output logic                     k,
    output logic                     ff_en,
    input  logic                     q_in,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               issued,
    output logic                     mismatch
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Count value on which the strobe fires and DRIVE hands over to SAMPLE.
    localparam logic [7:0]    CNT_LAST = 8'(TICK_DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    // JK command encodings ({j,k}).
    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [1:0]    mem_q [DEPTH];
    logic [1:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] jk_q, jk_d;
    logic [7:0] issued_q, issued_d;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);

    // A pop never relieves a full cycle: acceptance only looks at the registered level.
    assign push = cmd_valid && !full;

    // Next-state for the FIFO: write at the tail, advance pointers, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            mem_d[wr_ptr_q] = cmd;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);
    end

    // FIFO registers; reset discards any queued commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= CMD_HOLD;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Strobe is decoded straight from registered state so reset kills it at once.
    assign ff_en = (state_q == S_DRIVE) && (cnt_q == CNT_LAST);

    // Sequencer next-state: pop into DRIVE, count to the strobe, one SAMPLE cycle, chain or idle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        jk_d     = jk_q;
        issued_d = issued_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    jk_d    = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end
            end

            S_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_SAMPLE: begin
                issued_d = issued_q + 8'd1;
                if (!empty) begin
                    // Chain straight into the next command so there is no idle gap.
                    pop     = 1'b1;
                    jk_d    = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end else begin
                    jk_d    = CMD_HOLD;
                    state_d = S_IDLE;
                end
            end

            default: begin
                jk_d    = CMD_HOLD;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            jk_q     <= CMD_HOLD;
            issued_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            jk_q     <= jk_d;
            issued_q <= issued_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional JK reference model and q_in compare
    // ------------------------------------------------------------------
`ifdef JK_SEQ_CHECK_EN
    logic exp_q, exp_d;
    logic synced_q, synced_d;
    logic mismatch_q, mismatch_d;

    // Track the flip-flop's expected value on each strobe; compare in SAMPLE once synced.
    always_comb begin
        exp_d      = exp_q;
        synced_d   = synced_q;
        mismatch_d = mismatch_q;

        if (ff_en) begin
            case (jk_q)
                CMD_RESET:  exp_d = 1'b0;
                CMD_SET:    exp_d = 1'b1;
                CMD_TOGGLE: exp_d = ~exp_q;
                default:    exp_d = exp_q;
            endcase
            // The flip-flop itself has no reset, so its value is only known after a set or reset.
            if ((jk_q == CMD_RESET) || (jk_q == CMD_SET)) begin
                synced_d = 1'b1;
            end
        end

        if ((state_q == S_SAMPLE) && synced_q && (q_in != exp_q)) begin
            mismatch_d = 1'b1;
        end
    end

    // Model registers; mismatch is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q      <= 1'b0;
            synced_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            exp_q      <= exp_d;
            synced_q   <= synced_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    // Readback is ignored when the model is not built.
    logic unused_q_in;
    assign unused_q_in = q_in;
    assign mismatch    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready = !full;
    assign j         = jk_q[1];
    assign k         = jk_q[0];
    assign busy      = (state_q != S_IDLE) || !empty;
    assign level     = level_q;
    assign issued    = issued_q;

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Scoreboard bench for jk_cmd_seq: accepted commands queue their expected {j,k} and resulting q.
// A negedge monitor pops one entry per ff_en strobe and checks j/k and the flip-flop afterwards.
// Directed tests cover reset, latency, back-to-back spacing, full handling, mid-DRIVE reset and issued wrap.

module tb_jk_cmd_seq;

    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_ready;
    logic       j;
    logic       k;
    logic       ff_en;
    logic       q_in;
    logic       busy;
    logic [2:0] level;
    logic [7:0] issued;
    logic       mismatch;

    jk_cmd_seq #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .j         (j),
        .k         (k),
        .ff_en     (ff_en),
        .q_in      (q_in),
        .busy      (busy),
        .level     (level),
        .issued    (issued),
        .mismatch  (mismatch)
    );

    always #5 clk = ~clk;

    // Downstream flip-flop (no reset) and readback selection.
    logic ff_q   = 1'b0;
    logic rand_q = 1'b0;
    int   q_mode = 0;   // 0: real flip-flop, 1: stuck at 1, 2: random

    always @(posedge clk) begin
        if (ff_en) begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
        rand_q <= 1'($urandom_range(0, 1));
    end

    assign q_in = (q_mode == 0) ? ff_q : ((q_mode == 1) ? 1'b1 : rand_q);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    typedef struct packed {
        logic [1:0] cmd;
        logic       qexp;
        logic       qchk;
    } exp_t;

    exp_t sb[$];
    int   pulse_t[$];
    exp_t cur;
    bit   pend = 1'b0;

    // Monitor: every strobe consumes one expected command; the next cycle checks the flip-flop.
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (cur.qchk) chk("q_after_pulse", int'(ff_q), int'(cur.qexp));
        end
        if (rst_n && ff_en) begin
            pulse_t.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                cur = sb.pop_front();
                chk("jk_at_pulse", int'({j, k}), int'(cur.cmd));
                pend = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int last_acc = 0;

    task automatic push_cmd(input logic [1:0] c, input logic qe, input logic qc);
        int   n;
        bit   acc;
        exp_t e;
        n   = 0;
        acc = 1'b0;
        cmd       = c;
        cmd_valid = 1'b1;
        while (!acc && n < 200) begin
            acc = cmd_ready;
            tick(1);
            n++;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            chk("push_accept_timeout", 0, 1);
        end else begin
            e.cmd  = c;
            e.qexp = qe;
            e.qchk = qc;
            sb.push_back(e);
            last_acc = cyc;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        chk("idle_reached", int'(busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        pend = 1'b0;
        pulse_t.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic chk_spacing(input string name, input int first_acc, input int n_exp);
        int nbad;
        nbad = 0;
        chk({name, "_pulse_count"}, pulse_t.size(), n_exp);
        if (pulse_t.size() > 0) chk({name, "_first_latency"}, pulse_t[0] - first_acc, TICK_DIV);
        for (int i = 1; i < pulse_t.size(); i++) begin
            if (pulse_t[i] - pulse_t[i-1] != TICK_DIV + 1) nbad++;
        end
        chk({name, "_bad_spacings"}, nbad, 0);
    endtask

`ifdef JK_SEQ_CHECK_EN
    localparam int MISMATCH_AFTER_STUCK = 1;
`else
    localparam int MISMATCH_AFTER_STUCK = 0;
`endif

    logic [1:0] seq2 [5] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00};
    logic       q2   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] seq4 [8] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    logic       q4   [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int n;
        int idx;
        int nfull;
        int np;
        bit acc;
        exp_t e;

        // ---------------- Reset values ----------------
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_j", int'(j), 0);
        chk("rst_k", int'(k), 0);
        chk("rst_ff_en", int'(ff_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_issued", int'(issued), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // ---------------- Single set command ----------------
        push_cmd(2'b10, 1'b1, 1'b1);
        a0 = last_acc;
        chk("t1_level_after_push", int'(level), 1);
        chk("t1_j_before_pop", int'(j), 0);
        tick(1);
        chk("t1_j_drive", int'(j), 1);
        chk("t1_k_drive", int'(k), 0);
        chk("t1_no_early_strobe", int'(ff_en), 0);
        tick(3);
        chk("t1_ff_en_cycle", int'(ff_en), 1);
        chk("t1_j_at_strobe", int'(j), 1);
        tick(1);
        chk("t1_ff_en_single", int'(ff_en), 0);
        chk("t1_j_sample", int'(j), 1);
        chk("t1_issued_before", int'(issued), 0);
        tick(1);
        chk("t1_issued", int'(issued), 1);
        chk("t1_j_idle", int'(j), 0);
        chk("t1_busy_idle", int'(busy), 0);
        chk("t1_mismatch", int'(mismatch), 0);
        chk_spacing("t1", a0, 1);

        // ---------------- Back-to-back burst ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_cmd(seq2[i], q2[i], 1'b1);
            if (i == 0) a0 = last_acc;
        end
        chk("t2_level_full", int'(level), 4);
        chk("t2_ready_full", int'(cmd_ready), 0);
        wait_idle(100);
        chk("t2_issued", int'(issued), 5);
        chk("t2_level_end", int'(level), 0);
        chk("t2_sb_empty", sb.size(), 0);
        chk("t2_mismatch", int'(mismatch), 0);
        chk_spacing("t2", a0, 5);

        // ---------------- Unsynced toggles, then stuck readback ----------------
        do_reset();
        q_mode = 1;
        push_cmd(2'b11, 1'b0, 1'b0);
        push_cmd(2'b11, 1'b0, 1'b0);
        wait_idle(100);
        chk("t3_unsynced_mismatch", int'(mismatch), 0);
        push_cmd(2'b01, 1'b0, 1'b0);
        wait_idle(100);
        chk("t3_stuck_mismatch", int'(mismatch), MISMATCH_AFTER_STUCK);
        tick(5);
        chk("t3_mismatch_sticky", int'(mismatch), MISMATCH_AFTER_STUCK);
        q_mode = 0;

        // ---------------- Fill with cmd_valid held high ----------------
        do_reset();
        idx   = 0;
        nfull = 0;
        n     = 0;
        cmd_valid = 1'b1;
        while (idx < 8 && n < 200) begin
            cmd = seq4[idx];
            acc = cmd_ready;
            if (level == 3'(DEPTH)) begin
                nfull++;
                chk("t4_ready_when_full", int'(cmd_ready), 0);
            end
            tick(1);
            n++;
            if (acc) begin
                e.cmd  = seq4[idx];
                e.qexp = q4[idx];
                e.qchk = 1'b1;
                sb.push_back(e);
                idx++;
            end
        end
        cmd_valid = 1'b0;
        chk("t4_all_accepted", idx, 8);
        chk("t4_saw_full", int'(nfull > 0), 1);
        wait_idle(200);
        chk("t4_issued", int'(issued), 8);
        chk("t4_sb_empty", sb.size(), 0);
        chk("t4_mismatch", int'(mismatch), 0);

        // ---------------- Reset during the strobe cycle ----------------
        do_reset();
        push_cmd(2'b10, 1'b1, 1'b1);
        wait_idle(100);
        chk("t5_issued_pre", int'(issued), 1);
        push_cmd(2'b01, 1'b0, 1'b1);
        push_cmd(2'b11, 1'b1, 1'b1);
        push_cmd(2'b00, 1'b1, 1'b1);
        n = 0;
        while (!ff_en && n < 50) begin
            tick(1);
            n++;
        end
        chk("t5_strobe_reached", int'(ff_en), 1);
        #1;
        rst_n = 1'b0;
        sb.delete();
        pend = 1'b0;
        #1;
        chk("t5_ff_en_async", int'(ff_en), 0);
        chk("t5_j_async", int'(j), 0);
        chk("t5_k_async", int'(k), 0);
        chk("t5_level_async", int'(level), 0);
        chk("t5_issued_async", int'(issued), 0);
        chk("t5_ready_async", int'(cmd_ready), 1);
        tick(1);
        rst_n = 1'b1;
        np = pulse_t.size();
        tick(30);
        chk("t5_busy_after", int'(busy), 0);
        chk("t5_no_stale_pulses", pulse_t.size(), np);

        // ---------------- issued wrap with random readback ----------------
        do_reset();
        q_mode = 2;
        for (int i = 0; i < 260; i++) begin
            push_cmd(2'b00, 1'b0, 1'b0);
            if (i == 0) a0 = last_acc;
        end
        wait_idle(100);
        chk("t6_issued_wrap", int'(issued), 4);
        chk("t6_mismatch", int'(mismatch), 0);
        chk_spacing("t6", a0, 260);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
